// File: rtl/serial_add_sub_unit.sv
// ============================================================================
// Module   : serial_add_sub_unit (with add_sub_cell)
// Brief    : Bit-serial two's-complement adder/subtractor controller driving a
//            one-bit add/sub cell LSB-first. Optional macro:
//            SERIAL_ADD_SUB_SAT_EN (saturate result on signed overflow).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sel,
    output logic s,
    output logic cout
);
    logic w_b_eff;

    // Subtraction inverts B; the +1 comes in through the initial carry.
    assign w_b_eff = b ^ sel;
    assign s       = a ^ w_b_eff ^ cin;
    assign cout    = (a & w_b_eff) | (a & cin) | (w_b_eff & cin);
endmodule

module serial_add_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_ADD_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             sel_q,    sel_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic             w_cell_s;
    logic             w_cell_cout;

    add_sub_cell u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sel  (sel_q),
        .s    (w_cell_s),
        .cout (w_cell_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    sel_d   = sel;
                    carry_d = sel;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                carry_d  = w_cell_cout;
                result_d = {w_cell_s, result_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ w_cell_cout;
                    cout_d  = w_cell_cout;
                    cnt_d   = '0;
                    state_d = ST_DONE;
`ifdef SERIAL_ADD_SUB_SAT_EN
                    // a_sr_q[0] now holds the original sign bit of A.
                    if (carry_q ^ w_cell_cout) begin
                        result_d = a_sr_q[0] ? SAT_MIN : SAT_MAX;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub_unit.sv
// ============================================================================
// Module   : tb_serial_add_sub_unit
// Brief    : Scoreboard bench for serial_add_sub_unit (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sub_unit;
    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             sel   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    serial_add_sub_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sel      (sel),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic ss);
        exp_t             e;
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH:0]   full;
        b_eff = ss ? ~bb : bb;
        full  = {1'b0, aa} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ss};
        e.res = full[WIDTH-1:0];
        e.co  = full[WIDTH];
        e.ov  = (aa[WIDTH-1] == b_eff[WIDTH-1]) && (e.res[WIDTH-1] != aa[WIDTH-1]);
`ifdef SERIAL_ADD_SUB_SAT_EN
        if (e.ov) e.res = aa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("result",     64'(result),   64'(e.res));
                check_val("cout",       64'(cout),     64'(e.co));
                check_val("overflow",   64'(overflow), 64'(e.ov));
                check_val("done_cycle", 64'(cyc),      64'(e.cyc));
                check_val("busy_at_done", 64'(busy),   64'(0));
            end
        end
    end

    // Present operands for the next edge and record what must come out.
    task automatic present(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic ss);
        exp_t e;
        a     = aa;
        b     = bb;
        sel   = ss;
        start = 1'b1;
        e     = model(aa, bb, ss);
        e.cyc = cyc + 1 + WIDTH;
        sb.push_back(e);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic ss);
        present(aa, bb, ss);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            check_val("drain_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy",     64'(busy),     64'(0));
        check_val("rst_done",     64'(done),     64'(0));
        check_val("rst_result",   64'(result),   64'(0));
        check_val("rst_cout",     64'(cout),     64'(0));
        check_val("rst_overflow", 64'(overflow), 64'(0));
        @(posedge clk); #1;

        do_op(8'h05, 8'h03, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check_val("result_held", 64'(result), 64'(8'h08));

        do_op(8'h05, 8'h03, 1'b1); drain();
        do_op(8'h03, 8'h05, 1'b1); drain();
        do_op(8'h7F, 8'h01, 1'b0); drain();
        do_op(8'h80, 8'h01, 1'b1); drain();

        // start re-pulsed during the third busy cycle must be ignored
        do_op(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a = 8'hAA; b = 8'h55; sel = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        // start held high: accepted in every DONE cycle
        for (int i = 0; i < 6; i++) begin
            present(8'(i * 37 + 9), 8'(i * 91 + 200), 1'(i % 2));
            @(posedge clk); #1;
            a = 8'hFF; b = 8'hFF; sel = ~sel;
            repeat (WIDTH) @(posedge clk);
            #1;
        end
        start = 1'b0;
        drain();

        // rst during busy cycle 4 discards the operation
        a = 8'h33; b = 8'h44; sel = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst_busy",     64'(busy),     64'(0));
        check_val("midrst_done",     64'(done),     64'(0));
        check_val("midrst_result",   64'(result),   64'(0));
        check_val("midrst_cout",     64'(cout),     64'(0));
        check_val("midrst_overflow", 64'(overflow), 64'(0));
        repeat (WIDTH + 3) @(posedge clk);
        #1;
        do_op(8'h21, 8'h42, 1'b0); drain();

        for (int i = 0; i < 6; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom));
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
